// File: rtl/fft_tw_rotator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_tw_rotator                                               |
// | Description : Twiddle rotator for one radix-2 DIF stage. Walks the sample  |
// |               index k of each N = 2^TW_STAGE frame, drives the twiddle ROM |
// |               index, and multiplies each sample by W_N^idx (conjugated for |
// |               IFFT) through a 3-stage pipelined complex multiplier with    |
// |               half-up rounding and saturation. Valid/ready on both sides.  |
// | Ports       : clk, rst            clock, synchronous active-high reset     |
// |               stage, inv          stage number / IFFT flag (taken on sop)  |
// |               in_valid/ready/sop  input handshake, frame start             |
// |               in_re, in_im        input sample                             |
// |               tw_idx              ROM address (combinational)              |
// |               tw_re, tw_im        ROM data (cos, -sin), Q1.FRAC            |
// |               out_valid/ready     output handshake                         |
// |               out_last            sample with k = N-1                      |
// |               out_re, out_im      rotated sample                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fft_tw_rotator #(
  parameter int DW       = 18,
  parameter int TW_STAGE = 9,
  parameter int FRAC     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          stage,
  input  logic                inv,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sop,
  input  logic [DW-1:0]       in_re,
  input  logic [DW-1:0]       in_im,
  output logic [TW_STAGE-1:0] tw_idx,
  input  logic [DW-1:0]       tw_re,
  input  logic [DW-1:0]       tw_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [DW-1:0]       out_re,
  output logic [DW-1:0]       out_im
);

  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 1;
  localparam logic [TW_STAGE-1:0] C_K_LAST = '1;
  localparam logic signed [SW-1:0] C_HALF = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [SW-1:0] C_MAX  = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] C_MIN  = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Frame context
  logic [TW_STAGE-1:0] r_k;
  logic [3:0]          r_stage;
  logic                r_inv;

  logic                w_en;
  logic                w_accept;
  logic [TW_STAGE-1:0] w_k_eff;
  logic [3:0]          w_stage_eff;
  logic                w_inv_eff;
  logic [3:0]          w_h;
  logic                w_kbit;
  logic [TW_STAGE-1:0] w_mask;
  logic [TW_STAGE-1:0] w_j;

  // The whole pipe moves as one unit; it only stalls when the output is full.
  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en;
  assign w_accept = in_valid & w_en;

  assign w_k_eff     = in_sop ? '0    : r_k;
  assign w_stage_eff = in_sop ? stage : r_stage;
  assign w_inv_eff   = in_sop ? inv   : r_inv;

  // Butterfly span bit h selects the lower half; j is the offset inside the
  // group, scaled by 2^stage to address the full-size N-point ROM.
  assign w_h    = 4'(TW_STAGE - 1) - w_stage_eff;
  assign w_kbit = |(w_k_eff & (TW_STAGE'(1) << w_h));
  assign w_mask = {TW_STAGE{1'b1}} >> ({1'b0, w_stage_eff} + 5'd1);
  assign w_j    = w_k_eff & w_mask;
  assign tw_idx = w_kbit ? (w_j << w_stage_eff) : '0;

  // P1 operands, P2 products
  logic signed [DW-1:0] r_a, r_b, r_c, r_d;
  logic                 r_v1, r_last1;
  logic signed [PW-1:0] r_ac, r_bd, r_ad, r_bc;
  logic                 r_v2, r_last2;

  // P3 combine, round half-up, saturate
  logic signed [SW-1:0] w_re_s, w_im_s, w_re_r, w_im_r;

  assign w_re_s = SW'(r_ac) - SW'(r_bd);
  assign w_im_s = SW'(r_ad) + SW'(r_bc);
  assign w_re_r = (w_re_s + C_HALF) >>> FRAC;
  assign w_im_r = (w_im_s + C_HALF) >>> FRAC;

  function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] x);
    if (x > C_MAX)      return C_MAX[DW-1:0];
    else if (x < C_MIN) return C_MIN[DW-1:0];
    else                return x[DW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k       <= '0;
      r_stage   <= '0;
      r_inv     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_v1      <= 1'b0;
      r_last1   <= 1'b0;
      r_ac      <= '0;
      r_bd      <= '0;
      r_ad      <= '0;
      r_bc      <= '0;
      r_v2      <= 1'b0;
      r_last2   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      if (w_accept) begin
        r_k <= w_k_eff + TW_STAGE'(1);
        if (in_sop) begin
          r_stage <= stage;
          r_inv   <= inv;
        end
      end
      if (w_en) begin
        r_v1    <= w_accept;
        r_last1 <= w_accept & (w_k_eff == C_K_LAST);
        if (w_accept) begin
          r_a <= $signed(in_re);
          r_b <= $signed(in_im);
          r_c <= $signed(tw_re);
          r_d <= w_inv_eff ? -$signed(tw_im) : $signed(tw_im);
        end
        r_ac      <= PW'(r_a) * PW'(r_c);
        r_bd      <= PW'(r_b) * PW'(r_d);
        r_ad      <= PW'(r_a) * PW'(r_d);
        r_bc      <= PW'(r_b) * PW'(r_c);
        r_v2      <= r_v1;
        r_last2   <= r_v1 & r_last1;
        out_valid <= r_v2;
        out_last  <= r_v2 & r_last2;
        out_re    <= sat(w_re_r);
        out_im    <= sat(w_im_r);
      end
    end
  end

endmodule
`default_nettype wire
